// File: rtl/ascii_stream_pkg.sv
// Shared types and constants for the ROM-to-UART byte streamer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ascii_stream_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH,
    ST_LATCH,
    ST_CHECK,
    ST_SEND_CR,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

endpackage

// File: rtl/ascii_rom_streamer.sv
// Streams bytes from a BRAM ROM to a UART transmitter, optional LF->CR,LF, stops on NUL/last byte.
// Latency: start -> first tx_send is 5 cycles (IDLE, INIT, FETCH, LATCH, CHECK); min 4 cycles per byte plus tx time.
// Backpressure: tx_send only rises while tx_busy=0 and is held with stable tx_data until tx_busy is seen.
//
// Ports:
//   clk, rst (async, active-low)        clock and reset
//   start                               one-cycle request, honoured only in IDLE
//   rom_init / rom_re                   ROM rewind pulse / one-cycle read strobe
//   rom_dout / rom_end                  ROM byte and last-location flag, valid the cycle after rom_re
//   tx_data / tx_send / tx_busy         transmitter handshake
//   active / done / char_count          status: streaming, end pulse, bytes handed over since start
module ascii_rom_streamer
  import ascii_stream_pkg::*;
#(
  parameter int GAP_CYCLES  = 0,
  parameter bit INSERT_CR   = 1'b1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   rom_init,
  output logic                   rom_re,
  input  logic [7:0]             rom_dout,
  input  logic                   rom_end,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic                   active,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] char_count
);

  // A zero gap still needs a legal 1-bit counter.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  state_t          state;
  logic [7:0]      byte_q;
  logic            last_q;
  logic            cr_sent;   // CR accepted, waiting for the transmitter to free up before the LF
  logic [GW-1:0]   gap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rom_init   <= 1'b0;
      rom_re     <= 1'b0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      cr_sent    <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      // Strobes are registered: set on the transition into the state that owns them.
      rom_init <= 1'b0;
      rom_re   <= 1'b0;
      done     <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_INIT;
            rom_init   <= 1'b1;
            active     <= 1'b1;
            char_count <= '0;
          end
        end

        ST_INIT: begin
          rom_re <= 1'b1;
          state  <= ST_FETCH;
        end

        ST_FETCH: state <= ST_LATCH;

        ST_LATCH: begin
          byte_q <= rom_dout;
          last_q <= rom_end;
          state  <= ST_CHECK;
        end

        // Request is raised here when the transmitter is idle so SEND costs no extra cycle;
        // otherwise SEND/SEND_CR raise it once tx_busy drops.
        ST_CHECK: begin
          if (byte_q == ASCII_NUL) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (INSERT_CR && (byte_q == ASCII_LF)) begin
            state <= ST_SEND_CR;
            if (!tx_busy) begin
              tx_send <= 1'b1;
              tx_data <= ASCII_CR;
            end
          end else begin
            state <= ST_SEND;
            if (!tx_busy) begin
              tx_send <= 1'b1;
              tx_data <= byte_q;
            end
          end
        end

        ST_SEND_CR: begin
          if (!cr_sent) begin
            if (tx_send) begin
              if (tx_busy) begin
                tx_send    <= 1'b0;
                char_count <= char_count + 1'b1;
                cr_sent    <= 1'b1;
              end
            end else if (!tx_busy) begin
              tx_send <= 1'b1;
              tx_data <= ASCII_CR;
            end
          end else if (!tx_busy) begin
            cr_sent <= 1'b0;
            state   <= ST_SEND;
            tx_send <= 1'b1;
            tx_data <= byte_q;
          end
        end

        ST_SEND: begin
          if (tx_send) begin
            if (tx_busy) begin
              tx_send    <= 1'b0;
              char_count <= char_count + 1'b1;
              state      <= ST_WAIT_BUSY;
            end
          end else if (!tx_busy) begin
            tx_send <= 1'b1;
            tx_data <= byte_q;
          end
        end

        ST_WAIT_BUSY: begin
          if (!tx_busy) begin
            if (last_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (GAP_CYCLES == 0) begin
              rom_re <= 1'b1;
              state  <= ST_FETCH;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GW'(1)) begin
            rom_re <= 1'b1;
            state  <= ST_FETCH;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          active <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_rom_streamer.sv
// Directed bench: two streamers (GAP=0/CR on, GAP=5/CR off) with ROM and UART models.
// Latency: n/a.
// Backpressure: tx model stays busy 10 cycles per accepted byte; hold_busy forces extra stall.
module tb_ascii_rom_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [2];
  logic        hold_busy  [2];
  logic        rom_init   [2];
  logic        rom_re     [2];
  logic [7:0]  rom_dout   [2] = '{8'h00, 8'h00};
  logic        rom_end    [2] = '{1'b0, 1'b0};
  logic [7:0]  tx_data    [2];
  logic        tx_send    [2];
  logic        tx_busy    [2];
  logic        active     [2];
  logic        done       [2];
  logic [15:0] char_count [2];

  always #5 clk = ~clk;

  ascii_rom_streamer #(.GAP_CYCLES(0), .INSERT_CR(1'b1), .COUNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .rom_init(rom_init[0]), .rom_re(rom_re[0]),
    .rom_dout(rom_dout[0]), .rom_end(rom_end[0]), .tx_data(tx_data[0]), .tx_send(tx_send[0]),
    .tx_busy(tx_busy[0]), .active(active[0]), .done(done[0]), .char_count(char_count[0])
  );

  ascii_rom_streamer #(.GAP_CYCLES(5), .INSERT_CR(1'b0), .COUNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .rom_init(rom_init[1]), .rom_re(rom_re[1]),
    .rom_dout(rom_dout[1]), .rom_end(rom_end[1]), .tx_data(tx_data[1]), .tx_send(tx_send[1]),
    .tx_busy(tx_busy[1]), .active(active[1]), .done(done[1]), .char_count(char_count[1])
  );

  // ROM and transmitter models
  logic [7:0] rom_mem   [2][8];
  int         rom_len   [2] = '{0, 0};
  int         rom_addr  [2] = '{0, 0};
  logic       mbusy     [2] = '{1'b0, 1'b0};
  int         busy_left [2] = '{0, 0};
  logic [7:0] txlog     [2][32];
  int         txn       [2] = '{0, 0};

  assign tx_busy[0] = mbusy[0] | hold_busy[0];
  assign tx_busy[1] = mbusy[1] | hold_busy[1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rom_init[i]) begin
        rom_addr[i] <= 0;
      end else if (rom_re[i]) begin
        rom_dout[i] <= rom_mem[i][rom_addr[i] % 8];
        rom_end[i]  <= (rom_addr[i] == rom_len[i] - 1);
        rom_addr[i] <= rom_addr[i] + 1;
      end
      if (tx_send[i] && !tx_busy[i]) begin
        mbusy[i]     <= 1'b1;
        busy_left[i] <= 10;
        if (txn[i] < 32) txlog[i][txn[i]] <= tx_data[i];
        txn[i]       <= txn[i] + 1;
      end else if (busy_left[i] > 0) begin
        busy_left[i] <= busy_left[i] - 1;
        if (busy_left[i] == 1) mbusy[i] <= 1'b0;
      end
    end
  end

  // Protocol monitor, sampled on the falling edge
  int         cyc = 0;
  int         init_cnt [2] = '{0, 0};
  int         re_cnt   [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  int         init_cyc [2] = '{0, 0};
  int         first_re [2] = '{0, 0};
  int         fall_cyc [2] = '{0, 0};
  int         gap_meas [2] = '{0, 0};
  int         overlap  [2] = '{0, 0};
  int         send_viol[2] = '{0, 0};
  int         data_viol[2] = '{0, 0};
  logic       re_pend  [2] = '{1'b0, 1'b0};
  logic       prev_send[2] = '{1'b0, 1'b0};
  logic       prev_busy[2] = '{1'b0, 1'b0};
  logic [7:0] prev_data[2] = '{8'h00, 8'h00};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rom_init[i] && rom_re[i]) overlap[i] <= overlap[i] + 1;
      if (rom_init[i]) begin
        init_cnt[i] <= init_cnt[i] + 1;
        init_cyc[i] <= cyc;
        re_pend[i]  <= 1'b1;
      end
      if (rom_re[i]) begin
        re_cnt[i]   <= re_cnt[i] + 1;
        gap_meas[i] <= cyc - fall_cyc[i];
        if (re_pend[i]) begin
          first_re[i] <= cyc;
          re_pend[i]  <= 1'b0;
        end
      end
      if (prev_busy[i] && !tx_busy[i]) fall_cyc[i] <= cyc;
      if (tx_send[i] && !prev_send[i] && tx_busy[i]) send_viol[i] <= send_viol[i] + 1;
      if (tx_send[i] && prev_send[i] && (tx_data[i] != prev_data[i])) data_viol[i] <= data_viol[i] + 1;
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
      prev_send[i] <= tx_send[i];
      prev_busy[i] <= tx_busy[i];
      prev_data[i] <= tx_data[i];
    end
  end

  int vecs = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input int i, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int len);
    rom_mem[i][0] = b0;
    rom_mem[i][1] = b1;
    rom_mem[i][2] = b2;
    rom_mem[i][3] = b3;
    rom_len[i]    = len;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int base, input int budget, input string tag);
    int n = 0;
    while ((done_cnt[i] == base) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt[i] != base), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int b, d, ic, rc, n;

  initial begin
    rst = 1'b0;
    start = '{1'b0, 1'b0};
    hold_busy = '{1'b0, 1'b0};
    load_rom(0, 8'h48, 8'h69, 8'h0A, 8'h00, 3);
    load_rom(1, 8'h48, 8'h69, 8'h0A, 8'h00, 3);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_active",  32'(active[0]),   32'd0);
    check("rst_tx_send", 32'(tx_send[0]),  32'd0);
    check("rst_tx_data", 32'(tx_data[0]),  32'd0);
    check("rst_strobes", 32'({rom_init[0], rom_re[0], done[0]}), 32'd0);
    check("rst_count",   32'(char_count[1]), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // "Hi\n" with CR insertion
    b = txn[0]; d = done_cnt[0]; ic = init_cnt[0]; rc = re_cnt[0];
    pulse_start(0);
    check("t1_active", 32'(active[0]), 32'd1);
    wait_done(0, d, 400, "t1");
    check("t1_nbytes", 32'(txn[0] - b), 32'd4);
    check("t1_b0", 32'(txlog[0][b]),   32'h48);
    check("t1_b1", 32'(txlog[0][b+1]), 32'h69);
    check("t1_b2", 32'(txlog[0][b+2]), 32'h0D);
    check("t1_b3", 32'(txlog[0][b+3]), 32'h0A);
    check("t1_count", 32'(char_count[0]), 32'd4);
    check("t1_done_pulses", 32'(done_cnt[0] - d), 32'd1);
    check("t1_inits", 32'(init_cnt[0] - ic), 32'd1);
    check("t1_reads", 32'(re_cnt[0] - rc), 32'd3);
    check("t1_init_then_re", 32'(first_re[0] - init_cyc[0]), 32'd1);
    check("t1_idle", 32'(active[0]), 32'd0);

    // No CR insertion, GAP=5, start repeated mid-stream
    b = txn[1]; d = done_cnt[1]; ic = init_cnt[1];
    pulse_start(1);
    repeat (30) @(negedge clk);
    check("t2_mid_active", 32'(active[1]), 32'd1);
    pulse_start(1);
    wait_done(1, d, 600, "t2");
    check("t2_nbytes", 32'(txn[1] - b), 32'd3);
    check("t2_b0", 32'(txlog[1][b]),   32'h48);
    check("t2_b1", 32'(txlog[1][b+1]), 32'h69);
    check("t2_b2", 32'(txlog[1][b+2]), 32'h0A);
    check("t2_count", 32'(char_count[1]), 32'd3);
    check("t2_inits", 32'(init_cnt[1] - ic), 32'd1);
    check("t2_gap", 32'(gap_meas[1]), 32'd6);

    // NUL terminates before the end of ROM
    load_rom(0, 8'h41, 8'h42, 8'h00, 8'h43, 4);
    b = txn[0]; d = done_cnt[0]; rc = re_cnt[0];
    pulse_start(0);
    wait_done(0, d, 400, "t3");
    repeat (20) @(negedge clk);
    check("t3_nbytes", 32'(txn[0] - b), 32'd2);
    check("t3_b0", 32'(txlog[0][b]),   32'h41);
    check("t3_b1", 32'(txlog[0][b+1]), 32'h42);
    check("t3_reads", 32'(re_cnt[0] - rc), 32'd3);
    check("t3_count", 32'(char_count[0]), 32'd2);
    check("t3_done_pulses", 32'(done_cnt[0] - d), 32'd1);

    // Transmitter busy before the first byte is ready
    load_rom(0, 8'h48, 8'h69, 8'h0A, 8'h00, 3);
    hold_busy[0] = 1'b1;
    b = txn[0]; d = done_cnt[0];
    pulse_start(0);
    repeat (40) @(negedge clk);
    check("t4_held_send", 32'(tx_send[0]), 32'd0);
    check("t4_held_active", 32'(active[0]), 32'd1);
    hold_busy[0] = 1'b0;
    wait_done(0, d, 400, "t4");
    check("t4_nbytes", 32'(txn[0] - b), 32'd4);
    check("t4_b0", 32'(txlog[0][b]), 32'h48);
    check("t4_send_rule", 32'(send_viol[0]), 32'd0);
    check("t4_data_stable", 32'(data_viol[0]), 32'd0);

    // Asynchronous reset in the middle of SEND, then replay
    pulse_start(0);
    n = 0;
    while (!tx_send[0] && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_send", 32'(tx_send[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_arst_send",   32'(tx_send[0]), 32'd0);
    check("t5_arst_data",   32'(tx_data[0]), 32'd0);
    check("t5_arst_active", 32'(active[0]),  32'd0);
    check("t5_arst_re",     32'(rom_re[0]),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    b = txn[0]; d = done_cnt[0];
    pulse_start(0);
    wait_done(0, d, 400, "t5");
    check("t5_nbytes", 32'(txn[0] - b), 32'd4);
    check("t5_b0", 32'(txlog[0][b]), 32'h48);
    check("t5_count", 32'(char_count[0]), 32'd4);

    check("init_re_overlap", 32'(overlap[0] + overlap[1]), 32'd0);
    check("send_while_busy", 32'(send_viol[0] + send_viol[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
